mac_tx_arbiter: RTL and testbench

Round-robin transmit scheduler that shares the single Ethernet MAC transmit path between up to NUM_SRC packet sources, e.g. ARP, ICMP, DHCP and the UDP data stream. It grants one source at a time and registers that source's byte stream and destination MAC onto the MAC sender's inputs. After the source finishes, it waits for the MAC sender to drain its tail/CRC, then enforces an inter-packet gap before re-arbitrating. It sits directly upstream of the MAC sender and downstream of the protocol packet builders.

---
 rtl/mac_tx_arbiter.sv | 171 +++++++++++++++++
 tb/tb_mac_tx_arbiter.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mac_tx_arbiter.sv
// Round-robin scheduler sharing one MAC transmit path between NUM_SRC packet sources.
// Grants one source, forwards its byte stream one cycle late, then waits for MAC drain and the IFG.
module mac_tx_arbiter #(
    parameter int NUM_SRC       = 4,
    parameter int IFG_CYCLES    = 12,
    parameter int GRANT_TIMEOUT = 255
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [NUM_SRC-1:0]      src_req,
    input  logic [NUM_SRC-1:0]      src_tx_enable,
    input  logic [8*NUM_SRC-1:0]    src_data,
    input  logic [48*NUM_SRC-1:0]   src_dest_mac,
    input  logic                    mac_active,
    output logic [NUM_SRC-1:0]      grant,
    output logic                    mac_tx_enable,
    output logic [7:0]              mac_data,
    output logic [47:0]             mac_dest_mac,
    output logic                    busy,
    output logic                    timeout,
    output logic [2:0]              dbg_state
);

    localparam int                SEL_W    = $clog2(NUM_SRC);
    localparam logic [SEL_W-1:0]  LAST_RST = SEL_W'(NUM_SRC - 1);
    localparam logic [7:0]        TMO_LAST = 8'(GRANT_TIMEOUT - 1);
    localparam logic [7:0]        IFG_LAST = 8'(IFG_CYCLES - 1);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_GRANT = 3'd1,
        ST_SEND  = 3'd2,
        ST_DRAIN = 3'd3,
        ST_GAP   = 3'd4
    } state_t;

    state_t              state_q, state_d;
    logic [SEL_W-1:0]    last_q, last_d;
    logic [7:0]          cnt_q, cnt_d;
    logic [NUM_SRC-1:0]  grant_q, grant_d;
    logic                txen_q, txen_d;
    logic [7:0]          data_q, data_d;
    logic [47:0]         dest_q, dest_d;
    logic                timeout_q, timeout_d;

    logic [7:0]          data_arr [NUM_SRC];
    logic [47:0]         dest_arr [NUM_SRC];
    logic                rr_found;
    logic [SEL_W-1:0]    rr_sel;
    logic                sel_req;
    logic                sel_txen;

    for (genvar g = 0; g < NUM_SRC; g++) begin : g_unpack
        assign data_arr[g] = src_data[8*g +: 8];
        assign dest_arr[g] = src_dest_mac[48*g +: 48];
    end

    // Once granted, last_q is the selected source until the next arbitration.
    assign sel_req  = src_req[last_q];
    assign sel_txen = src_tx_enable[last_q];

    // Search starts just after the previous winner so every requester waits at most NUM_SRC-1 turns.
    always_comb begin
        rr_found = 1'b0;
        rr_sel   = last_q;
        for (int i = 1; i <= NUM_SRC; i++) begin
            if (!rr_found && src_req[SEL_W'((int'(last_q) + i) % NUM_SRC)]) begin
                rr_found = 1'b1;
                rr_sel   = SEL_W'((int'(last_q) + i) % NUM_SRC);
            end
        end
    end

    // Handshake: src_req is a level request, grant answers it; the granted source owns the MAC
    // from its first src_tx_enable byte until src_tx_enable drops, one byte per clock.
    always_comb begin
        state_d   = state_q;
        last_d    = last_q;
        cnt_d     = cnt_q;
        grant_d   = grant_q;
        dest_d    = dest_q;
        txen_d    = 1'b0;
        data_d    = 8'd0;
        timeout_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (rr_found) begin
                    grant_d         = '0;
                    grant_d[rr_sel] = 1'b1;
                    dest_d          = dest_arr[rr_sel];
                    last_d          = rr_sel;
                    cnt_d           = 8'd0;
                    state_d         = ST_GRANT;
                end
            end
            ST_GRANT: begin
                if (sel_txen) begin
                    txen_d  = 1'b1;
                    data_d  = data_arr[last_q];
                    state_d = ST_SEND;
                end else if (!sel_req) begin
                    grant_d = '0;
                    state_d = ST_IDLE;
                end else if (cnt_q == TMO_LAST) begin
                    grant_d   = '0;
                    timeout_d = 1'b1;
                    state_d   = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            ST_SEND: begin
                if (sel_txen) begin
                    txen_d = 1'b1;
                    data_d = data_arr[last_q];
                end else begin
                    grant_d = '0;
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (!mac_active) begin
                    cnt_d   = 8'd0;
                    state_d = ST_GAP;
                end
            end
            ST_GAP: begin
                if (cnt_q == IFG_LAST) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: begin
                grant_d = '0;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            last_q    <= LAST_RST;
            cnt_q     <= 8'd0;
            grant_q   <= '0;
            txen_q    <= 1'b0;
            data_q    <= 8'd0;
            dest_q    <= 48'd0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            last_q    <= last_d;
            cnt_q     <= cnt_d;
            grant_q   <= grant_d;
            txen_q    <= txen_d;
            data_q    <= data_d;
            dest_q    <= dest_d;
            timeout_q <= timeout_d;
        end
    end

    assign grant         = grant_q;
    assign mac_tx_enable = txen_q;
    assign mac_data      = data_q;
    assign mac_dest_mac  = dest_q;
    assign busy          = (state_q != ST_IDLE);
    assign timeout       = timeout_q;
    assign dbg_state     = state_q;

endmodule

// File: tb/tb_mac_tx_arbiter.sv
// Randomized bench for mac_tx_arbiter: round-robin model, byte scoreboard and a simple MAC sender model.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_mac_tx_arbiter;

    localparam int NUM_SRC       = 4;
    localparam int IFG_CYCLES    = 12;
    localparam int GRANT_TIMEOUT = 255;

    logic                   clock = 1'b0;
    logic                   reset;
    logic [NUM_SRC-1:0]     src_req;
    logic [NUM_SRC-1:0]     src_tx_enable;
    logic [8*NUM_SRC-1:0]   src_data;
    logic [48*NUM_SRC-1:0]  src_dest_mac;
    logic                   mac_active;
    logic [NUM_SRC-1:0]     grant;
    logic                   mac_tx_enable;
    logic [7:0]             mac_data;
    logic [47:0]            mac_dest_mac;
    logic                   busy;
    logic                   timeout;
    logic [2:0]             dbg_state;

    logic                   drv_txen [NUM_SRC];
    logic [7:0]             drv_data [NUM_SRC];
    logic [47:0]            dest_tbl [NUM_SRC];
    logic [7:0]             exp_q [$];

    int n_checks = 0;
    int n_fail   = 0;
    int model_last;
    int mac_tail_len;
    int mac_tail;
    bit mon_en = 1'b0;
    logic        prev_active = 1'b0;
    logic [47:0] prev_dest   = 48'd0;

    always #5 clock = ~clock;

    for (genvar g = 0; g < NUM_SRC; g++) begin : g_pack
        assign src_tx_enable[g]         = drv_txen[g];
        assign src_data[8*g +: 8]       = drv_data[g];
        assign src_dest_mac[48*g +: 48] = dest_tbl[g];
    end

    mac_tx_arbiter #(
        .NUM_SRC       (NUM_SRC),
        .IFG_CYCLES    (IFG_CYCLES),
        .GRANT_TIMEOUT (GRANT_TIMEOUT)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .src_req       (src_req),
        .src_tx_enable (src_tx_enable),
        .src_data      (src_data),
        .src_dest_mac  (src_dest_mac),
        .mac_active    (mac_active),
        .grant         (grant),
        .mac_tx_enable (mac_tx_enable),
        .mac_data      (mac_data),
        .mac_dest_mac  (mac_dest_mac),
        .busy          (busy),
        .timeout       (timeout),
        .dbg_state     (dbg_state)
    );

    // MAC sender: active while bytes arrive, then mac_tail_len more cycles of padding/CRC.
    always @(posedge clock) begin
        if (reset) begin
            mac_active <= 1'b0;
            mac_tail   <= 0;
        end else if (mac_tx_enable) begin
            mac_active <= 1'b1;
            mac_tail   <= mac_tail_len;
        end else if (mac_tail > 0) begin
            mac_tail <= mac_tail - 1;
        end else begin
            mac_active <= 1'b0;
        end
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: observed 0x%0h, expected 0x%0h (t=%0t)", tag, got, want, $time);
        end
    endtask

    task automatic tick();
        @(negedge clock);
    endtask

    function automatic int rr_pick(input int last, input logic [NUM_SRC-1:0] req);
        int idx;
        for (int k = 1; k <= NUM_SRC; k++) begin
            idx = (last + k) % NUM_SRC;
            if (((req >> idx) & 1) != 0) return idx;
        end
        return -1;
    endfunction

    // Invariants that hold on every cycle out of reset.
    always @(negedge clock) begin
        if (mon_en) begin
            check_eq("grant_onehot", ($countones(grant) <= 1), 1);
            if (!mac_tx_enable) check_eq("idle_data_zero", mac_data, 0);
            if (prev_active && mac_active) check_eq("dest_stable_active", mac_dest_mac, prev_dest);
        end
        prev_active = mac_active;
        prev_dest   = mac_dest_mac;
    end

    task automatic expect_grant(input string tag, output int sel);
        sel = rr_pick(model_last, src_req);
        if (sel < 0) begin
            check_eq(tag, grant, 0);
        end else begin
            check_eq(tag, grant, NUM_SRC'(1) << sel);
            check_eq({tag, "_dest"}, mac_dest_mac, dest_tbl[sel]);
            check_eq({tag, "_busy"}, busy, 1);
            check_eq({tag, "_txen"}, mac_tx_enable, 0);
            model_last = sel;
        end
    endtask

    task automatic send_bytes(input int src, input int n, input int pattern);
        logic [7:0] b;
        for (int k = 0; k < n; k++) begin
            b = (pattern >= 0) ? 8'(pattern + k) : 8'($urandom_range(0, 255));
            for (int j = 0; j < NUM_SRC; j++) begin
                if (j == src) begin
                    drv_txen[j] = 1'b1;
                    drv_data[j] = b;
                end else begin
                    drv_txen[j] = 1'($urandom_range(0, 1));
                    drv_data[j] = 8'($urandom_range(0, 255));
                end
            end
            exp_q.push_back(b);
            tick();
            check_eq("send_txen", mac_tx_enable, 1);
            check_eq("send_data", mac_data, exp_q.pop_front());
            check_eq("send_grant", grant, NUM_SRC'(1) << src);
        end
    endtask

    task automatic end_frame(input bit keep_req);
        for (int j = 0; j < NUM_SRC; j++) begin
            drv_txen[j] = 1'b0;
            drv_data[j] = 8'($urandom_range(0, 255));
        end
        if (!keep_req) src_req = '0;
        tick();
        check_eq("eof_txen", mac_tx_enable, 0);
        check_eq("eof_data", mac_data, 0);
        check_eq("eof_grant", grant, 0);
        check_eq("eof_busy", busy, 1);
    endtask

    task automatic drain_and_gap(input bit keep_req, output int next_sel);
        int n;
        n = 0;
        while (mac_active === 1'b1 && n < 200) begin
            check_eq("drain_no_grant", grant, 0);
            check_eq("drain_busy", busy, 1);
            tick();
            n++;
        end
        check_eq("drain_mac_idle", mac_active, 0);
        n = 0;
        while (busy === 1'b1 && n < 300) begin
            check_eq("gap_no_grant", grant, 0);
            tick();
            n++;
        end
        check_eq("gap_len", n, IFG_CYCLES + 1);
        next_sel = -1;
        if (keep_req) begin
            tick();
            expect_grant("regrant_after_gap", next_sel);
        end
    endtask

    task automatic frame_and_gap(input int src, input int len, input int pattern,
                                 input bit keep_req, output int next_sel);
        mac_tail_len = $urandom_range(0, 24);
        send_bytes(src, len, pattern);
        end_frame(keep_req);
        drain_and_gap(keep_req, next_sel);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: bench did not finish, dut state=%0d", dbg_state);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int sel, nxt, hi, pulses, n;
        reset        = 1'b1;
        src_req      = '0;
        mac_tail_len = 4;
        model_last   = NUM_SRC - 1;
        for (int j = 0; j < NUM_SRC; j++) begin
            drv_txen[j] = 1'b0;
            drv_data[j] = 8'd0;
            dest_tbl[j] = {16'($urandom), 32'($urandom)};
        end
        repeat (3) tick();

        check_eq("rst_grant", grant, 0);
        check_eq("rst_txen", mac_tx_enable, 0);
        check_eq("rst_data", mac_data, 0);
        check_eq("rst_dest", mac_dest_mac, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_timeout", timeout, 0);
        reset  = 1'b0;
        mon_en = 1'b1;
        tick();
        check_eq("idle_busy", busy, 0);

        // Single source with a known frame.
        dest_tbl[2] = 48'h0A0B0C0D0E0F;
        src_req[2]  = 1'b1;
        tick();
        expect_grant("single_grant", sel);
        frame_and_gap(sel, 60, 0, 1'b0, nxt);

        // Grant timeout, then the next requester in order takes over.
        src_req = 4'b0010;
        tick();
        expect_grant("tmo_grant", sel);
        src_req[2] = 1'b1;
        hi = 1;
        pulses = 0;
        n = 0;
        while (grant[1] === 1'b1 && n < 400) begin
            check_eq("tmo_txen", mac_tx_enable, 0);
            tick();
            n++;
            if (grant[1] === 1'b1) hi++;
            if (timeout === 1'b1) pulses++;
        end
        check_eq("tmo_grant_cycles", hi, GRANT_TIMEOUT);
        check_eq("tmo_pulse_at_drop", timeout, 1);
        check_eq("tmo_idle", busy, 0);
        tick();
        if (timeout === 1'b1) pulses++;
        check_eq("tmo_pulse_count", pulses, 1);
        expect_grant("tmo_next_grant", sel);
        src_req[1] = 1'b0;
        frame_and_gap(sel, $urandom_range(1, 20), -1, 1'b0, nxt);

        // Abort before the first byte returns straight to IDLE.
        src_req = 4'b1000;
        tick();
        expect_grant("abort_grant", sel);
        repeat (2) begin
            tick();
            check_eq("abort_hold", grant, NUM_SRC'(1) << sel);
            check_eq("abort_txen", mac_tx_enable, 0);
        end
        src_req = 4'b0001;
        tick();
        check_eq("abort_grant_clear", grant, 0);
        check_eq("abort_no_gap_idle", busy, 0);
        check_eq("abort_txen_low", mac_tx_enable, 0);
        tick();
        expect_grant("abort_next_grant", sel);
        frame_and_gap(sel, $urandom_range(1, 16), -1, 1'b0, nxt);

        // Short frame with the request held: wait for drain and gap.
        src_req = 4'b0001;
        tick();
        expect_grant("hold_grant", sel);
        frame_and_gap(sel, 5, -1, 1'b1, nxt);
        frame_and_gap(nxt, $urandom_range(1, 12), -1, 1'b0, sel);

        // All sources requesting: strict rotation.
        src_req = '1;
        tick();
        expect_grant("fair_first", sel);
        for (int i = 0; i <= NUM_SRC; i++) begin
            frame_and_gap(sel, 10, -1, (i < NUM_SRC), nxt);
            sel = nxt;
        end

        // Reset in the middle of a frame.
        src_req = 4'b0100;
        tick();
        expect_grant("rst_case_grant", sel);
        mac_tail_len = 6;
        send_bytes(sel, 20, -1);
        mon_en = 1'b0;
        reset  = 1'b1;
        drv_txen[sel] = 1'b1;
        drv_data[sel] = 8'($urandom_range(0, 255));
        tick();
        check_eq("midrst_grant", grant, 0);
        check_eq("midrst_txen", mac_tx_enable, 0);
        check_eq("midrst_data", mac_data, 0);
        check_eq("midrst_dest", mac_dest_mac, 0);
        check_eq("midrst_busy", busy, 0);
        check_eq("midrst_timeout", timeout, 0);
        reset = 1'b0;
        for (int j = 0; j < NUM_SRC; j++) drv_txen[j] = 1'b0;
        src_req    = 4'b1001;
        model_last = NUM_SRC - 1;
        tick();
        mon_en = 1'b1;
        expect_grant("post_rst_first", sel);
        frame_and_gap(sel, 8, -1, 1'b1, nxt);
        frame_and_gap(nxt, 8, -1, 1'b0, sel);

        check_eq("scoreboard_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
